// File: rtl/memory_dumper_if.sv
// Host-side readback stream between the memory dumper and its consumer.
// master: dumper drives byte/address/valid; slave: host drives ready.
interface memory_dumper_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [7:0]            dump_data;
  logic [ADDR_WIDTH-1:0] dump_addr;
  logic                  dump_valid;
  logic                  dump_ready;

  modport master (
    output dump_data,
    output dump_addr,
    output dump_valid,
    input  dump_ready
  );

  modport slave (
    input  dump_data,
    input  dump_addr,
    input  dump_valid,
    output dump_ready
  );
endinterface

// File: rtl/memory_dumper.sv
// SAP-1 RAM readback: walks every address via MAR/RAM control and streams
// each byte to the host. Ports: clk, resetn, dumping, bus, out, dif, done.
module memory_dumper #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  dumping,
  inout  wire  [7:0]            bus,
  output logic [14:0]           out,
  memory_dumper_if.master       dif,
  output logic                  done
);

  localparam logic [14:0] IDLE_CW = 15'h0FE3;
  localparam logic [14:0] ADDR_CW = 15'h07E3;
  localparam logic [14:0] READ_CW = 15'h0DE3;
  localparam logic [ADDR_WIDTH-1:0] LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_READ,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  logic [14:0]           out_q, out_d;
  logic                  oe_q, oe_d;
  logic [7:0]            drv_q, drv_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    daddr_d = daddr_q;
    valid_d = valid_q;
    done_d  = done_q;
    if (!dumping) begin
      state_d = S_IDLE;
      addr_d  = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ADDR;
          addr_d  = '0;
        end
        S_ADDR: state_d = S_READ;
        S_READ: begin
          // RAM drives the bus during READ; capture it on the way out.
          state_d = S_PRESENT;
          data_d  = bus;
          daddr_d = addr_q;
          valid_d = 1'b1;
        end
        S_PRESENT: begin
          if (dif.dump_ready) begin
            valid_d = 1'b0;
            if (addr_q == LAST) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_ADDR;
              addr_d  = addr_q + 1'b1;
            end
          end
        end
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= 8'h00;
      daddr_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      daddr_q <= daddr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Control word and bus enable launch half a cycle early so they are
  // settled when MAR/RAM sample on the following rising edge.
  always_comb begin
    out_d = IDLE_CW;
    oe_d  = 1'b0;
    drv_d = {{(8-ADDR_WIDTH){1'b0}}, addr_q};
    unique case (state_q)
      S_ADDR: begin
        out_d = ADDR_CW;
        oe_d  = 1'b1;
      end
      S_READ: out_d = READ_CW;
      default: begin
        out_d = IDLE_CW;
        oe_d  = 1'b0;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (!resetn) begin
      out_q <= IDLE_CW;
      oe_q  <= 1'b0;
      drv_q <= 8'h00;
    end else begin
      out_q <= out_d;
      oe_q  <= oe_d;
      drv_q <= drv_d;
    end
  end

  assign bus            = oe_q ? drv_q : 8'hzz;
  assign out            = out_q;
  assign dif.dump_data  = data_q;
  assign dif.dump_addr  = daddr_q;
  assign dif.dump_valid = valid_q;
  assign done           = done_q;

endmodule
